interrupt_controller: RTL and testbench



---
 rtl/intc_pkg.sv | 20 ++
 rtl/intc_prio_enc.sv | 46 ++++
 rtl/interrupt_controller.sv | 152 +++++++++++++++
 tb/tb_interrupt_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared state type, NMI vector constant and vector numbering for interrupt_controller.
// INTC_NMI_PREEMPT_EN enables the NMI_ASSERT/NMI_SERVICE states in the top level.
package intc_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ASSERT      = 3'd1,
    SERVICE     = 3'd2,
    NMI_ASSERT  = 3'd3,
    NMI_SERVICE = 3'd4
  } intc_state_e;

  localparam int unsigned NMI_VEC = 32'd0;

  // Maskable source idx is reported as vector idx+1; vector 0 belongs to the NMI.
  function automatic logic [15:0] vec_from_idx(input int unsigned idx);
    return 16'(idx + 32'd1);
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: NMI first, then the lowest-index eligible maskable source.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = 3
) (
  input  logic [NUM_IRQ-1:0] elig,
  input  logic               nmi_pend,
  output logic               valid,
  output logic [VEC_W-1:0]   vector,
  output logic               INA
);

  localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1'b1);

  logic [NUM_IRQ-1:0] lowest_s;
  logic [VEC_W-1:0]   mask_vec_s;

  // Two's-complement trick isolates the lowest set bit.
  assign lowest_s = elig & (~elig + ONE);

  always_comb begin
    mask_vec_s = {VEC_W{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      mask_vec_s = mask_vec_s |
                   (lowest_s[i] ? VEC_W'(vec_from_idx(unsigned'(i))) : {VEC_W{1'b0}});
    end
  end

  always_comb begin
    valid  = 1'b0;
    vector = {VEC_W{1'b0}};
    INA    = 1'b0;
    if (nmi_pend) begin
      valid  = 1'b1;
      vector = VEC_W'(NMI_VEC);
      INA    = 1'b0;
    end else begin
      valid  = |elig;
      vector = mask_vec_s;
      INA    = |elig;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller with acknowledged request/service handshake to the CPU.
// Define INTC_NMI_PREEMPT_EN to let a pending NMI preempt a maskable handler (one-deep save).
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               INTD,
  input  logic               en_wr,
  input  logic [NUM_IRQ-1:0] en_wdata,
  input  logic               cpu_boundary,
  input  logic               cpu_ack,
  input  logic               cpu_eret,
  output logic               cpu_irq,
  output logic               INA,
  output logic [VEC_W-1:0]   vector,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] irq_en
);

  intc_state_e        state_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d, irq_en_q, irq_prev_q;
  logic [NUM_IRQ-1:0] irq_rise_s, elig_s, pend_clr_s;
  logic               nmi_pend_q, nmi_pend_d, nmi_prev_q, nmi_clr_s;
  logic               cpu_irq_q, ina_q, in_service_q, ack_mask_s;
  logic [VEC_W-1:0]   vector_q;
  logic               enc_valid_s, enc_ina_s;
  logic [VEC_W-1:0]   enc_vec_s;
`ifdef INTC_NMI_PREEMPT_EN
  logic [VEC_W-1:0]   saved_vec_q;
`endif

  assign irq_rise_s = irq_in & ~irq_prev_q;
  assign elig_s     = INTD ? {NUM_IRQ{1'b0}} : (pending_q & irq_en_q);
  assign ack_mask_s = (state_q == ASSERT) && cpu_ack && ina_q;
  assign nmi_clr_s  = cpu_ack && (((state_q == ASSERT) && !ina_q) || (state_q == NMI_ASSERT));

  // The frozen vector selects which pending bit the acknowledge retires.
  always_comb begin
    pend_clr_s = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_clr_s[i] = ack_mask_s && (vector_q == VEC_W'(vec_from_idx(unsigned'(i))));
    end
  end

  // A new edge outranks a same-cycle clear.
  assign pending_d  = (pending_q & ~pend_clr_s) | irq_rise_s;
  assign nmi_pend_d = (nmi_pend_q & ~nmi_clr_s) | (nmi_in & ~nmi_prev_q);

  intc_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .elig     (elig_s),
    .nmi_pend (nmi_pend_q),
    .valid    (enc_valid_s),
    .vector   (enc_vec_s),
    .INA      (enc_ina_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= {NUM_IRQ{1'b0}};
      nmi_pend_q   <= 1'b0;
      irq_en_q     <= {NUM_IRQ{1'b1}};
      irq_prev_q   <= {NUM_IRQ{1'b0}};
      nmi_prev_q   <= 1'b0;
      cpu_irq_q    <= 1'b0;
      ina_q        <= 1'b0;
      vector_q     <= {VEC_W{1'b0}};
      in_service_q <= 1'b0;
`ifdef INTC_NMI_PREEMPT_EN
      saved_vec_q  <= {VEC_W{1'b0}};
`endif
    end else begin
      irq_prev_q <= irq_in;
      nmi_prev_q <= nmi_in;
      pending_q  <= pending_d;
      nmi_pend_q <= nmi_pend_d;
      if (en_wr) begin
        irq_en_q <= en_wdata;
      end
      case (state_q)
        IDLE: begin
          if (cpu_boundary && enc_valid_s) begin
            state_q   <= ASSERT;
            cpu_irq_q <= 1'b1;
            vector_q  <= enc_vec_s;
            ina_q     <= enc_ina_s;
          end
        end
        ASSERT: begin
          if (cpu_ack) begin
            state_q      <= SERVICE;
            cpu_irq_q    <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (cpu_eret) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
`ifdef INTC_NMI_PREEMPT_EN
          else if (ina_q && nmi_pend_q && cpu_boundary) begin
            state_q     <= NMI_ASSERT;
            saved_vec_q <= vector_q;
            vector_q    <= VEC_W'(NMI_VEC);
            ina_q       <= 1'b0;
            cpu_irq_q   <= 1'b1;
          end
`endif
        end
`ifdef INTC_NMI_PREEMPT_EN
        NMI_ASSERT: begin
          if (cpu_ack) begin
            state_q   <= NMI_SERVICE;
            cpu_irq_q <= 1'b0;
          end
        end
        NMI_SERVICE: begin
          if (cpu_eret) begin
            state_q  <= SERVICE;
            vector_q <= saved_vec_q;
            ina_q    <= 1'b1;
          end
        end
`endif
        default: begin
          state_q      <= IDLE;
          cpu_irq_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq    = cpu_irq_q;
  assign INA        = ina_q;
  assign vector     = vector_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign irq_en     = irq_en_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised bench for interrupt_controller with a behavioural reference model and directed pins.
module tb_interrupt_controller;

  localparam int NUM_IRQ = 4;
  localparam int VEC_W   = 3;

  localparam int S_IDLE  = 0;
  localparam int S_PRES  = 1;
  localparam int S_SERV  = 2;
  localparam int S_NPRES = 3;
  localparam int S_NSERV = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic               nmi_in = 1'b0;
  logic               INTD = 1'b0;
  logic               en_wr = 1'b0;
  logic [NUM_IRQ-1:0] en_wdata = '0;
  logic               cpu_boundary = 1'b0;
  logic               cpu_ack = 1'b0;
  logic               cpu_eret = 1'b0;
  logic               cpu_irq, INA, in_service;
  logic [VEC_W-1:0]   vector;
  logic [NUM_IRQ-1:0] pending, irq_en;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // reference model state
  int                 m_stage = S_IDLE;
  logic [NUM_IRQ-1:0] m_pend = '0, m_en = '1, m_prev = '0;
  bit                 m_nmi = 1'b0, m_nprev = 1'b0, m_mask = 1'b0;
  int                 m_vec = 0, m_saved = 0;

  interrupt_controller #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .nmi_in(nmi_in), .INTD(INTD),
    .en_wr(en_wr), .en_wdata(en_wdata), .cpu_boundary(cpu_boundary),
    .cpu_ack(cpu_ack), .cpu_eret(cpu_eret), .cpu_irq(cpu_irq), .INA(INA),
    .vector(vector), .in_service(in_service), .pending(pending), .irq_en(irq_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve();
    cpu_ack = 1'b1;
    tick();
    cpu_ack  = 1'b0;
    cpu_eret = 1'b1;
    tick();
    cpu_eret = 1'b0;
  endtask

  // Model: what the controller must hold after this clock edge, from the behavioural rules.
  task automatic model_step();
    logic [NUM_IRQ-1:0] rise, clr;
    bit nclr;
    int win;
    if (rst) begin
      m_stage = S_IDLE; m_pend = '0; m_nmi = 1'b0; m_en = '1; m_prev = '0;
      m_nprev = 1'b0; m_vec = 0; m_mask = 1'b0; m_saved = 0;
      return;
    end
    rise = irq_in & ~m_prev;
    clr  = '0;
    nclr = 1'b0;
    case (m_stage)
      S_IDLE: begin
        if (cpu_boundary) begin
          win = -1;
          if (m_nmi) win = 0;
          else if (!INTD) begin
            for (int i = NUM_IRQ - 1; i >= 0; i--)
              if (m_pend[i] && m_en[i]) win = i + 1;
          end
          if (win >= 0) begin
            m_stage = S_PRES;
            m_vec   = win;
            m_mask  = (win != 0);
          end
        end
      end
      S_PRES: begin
        if (cpu_ack) begin
          m_stage = S_SERV;
          if (m_mask) clr[m_vec-1] = 1'b1;
          else nclr = 1'b1;
        end
      end
      S_SERV: begin
        if (cpu_eret) m_stage = S_IDLE;
`ifdef INTC_NMI_PREEMPT_EN
        else if (m_mask && m_nmi && cpu_boundary) begin
          m_saved = m_vec; m_vec = 0; m_mask = 1'b0; m_stage = S_NPRES;
        end
`endif
      end
      S_NPRES: begin
        if (cpu_ack) begin
          m_stage = S_NSERV;
          nclr = 1'b1;
        end
      end
      S_NSERV: begin
        if (cpu_eret) begin
          m_stage = S_SERV; m_vec = m_saved; m_mask = 1'b1;
        end
      end
      default: m_stage = S_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    m_nmi  = (m_nmi && !nclr) || (nmi_in && !m_nprev);
    if (en_wr) m_en = en_wdata;
    m_prev  = irq_in;
    m_nprev = nmi_in;
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [13:0] exp_v, act_v;
    bit e_irq, e_srv;
    if (chk_en) begin
      e_irq = (m_stage == S_PRES) || (m_stage == S_NPRES);
      e_srv = (m_stage == S_SERV) || (m_stage == S_NPRES) || (m_stage == S_NSERV);
      exp_v = {e_irq, m_mask, 3'(m_vec), e_srv, m_pend, m_en};
      act_v = {cpu_irq, INA, vector, in_service, pending, irq_en};
      check("cycle_outputs", 32'(act_v), 32'(exp_v));
    end
  end

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
    check("rst_irq_en", 32'(irq_en), 32'hF);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_vector", 32'(vector), 32'd0);
    rst = 1'b0;
    cpu_boundary = 1'b1;

    // single source, latency and handshake
    irq_in = 4'b0100;
    tick();
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_irq_early", 32'(cpu_irq), 32'd0);
    tick();
    check("t1_irq", 32'(cpu_irq), 32'd1);
    check("t1_vector", 32'(vector), 32'd3);
    check("t1_ina", 32'(INA), 32'd1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check("t1_pend_clr", 32'(pending), 32'd0);
    check("t1_in_service", 32'(in_service), 32'd1);
    cpu_eret = 1'b1;
    tick();
    cpu_eret = 1'b0;
    check("t1_idle", 32'({cpu_irq, in_service}), 32'd0);
    irq_in = '0;
    tick();

    // simultaneous edges: NMI, then 2, then 4
    irq_in = 4'b1010; nmi_in = 1'b1;
    tick();
    tick();
    check("t2_nmi_vec", 32'({INA, vector}), 32'd0);
    serve();
    tick();
    check("t2_vec2", 32'(vector), 32'd2);
    serve();
    tick();
    check("t2_vec4", 32'(vector), 32'd4);
    serve();
    irq_in = '0; nmi_in = 1'b0;
    tick();

    // INTD masks only the maskable sources
    INTD = 1'b1; irq_in = 4'b0001;
    tick(); tick(); tick();
    check("t3_masked", 32'(cpu_irq), 32'd0);
    nmi_in = 1'b1;
    tick(); tick();
    check("t3_nmi", 32'({cpu_irq, vector}), 32'({1'b1, 3'd0}));
    serve();
    INTD = 1'b0;
    tick();
    check("t3_vec1", 32'(vector), 32'd1);
    serve();
    irq_in = '0; nmi_in = 1'b0;
    tick();

    // presented request stays frozen
    irq_in = 4'b0010;
    tick(); tick();
    en_wr = 1'b1; en_wdata = 4'b0000; INTD = 1'b1;
    tick();
    en_wr = 1'b0;
    check("t4_frozen_vec", 32'(vector), 32'd2);
    check("t4_irq_en", 32'(irq_en), 32'd0);
    tick();
    check("t4_still_irq", 32'({cpu_irq, vector}), 32'({1'b1, 3'd2}));
    serve();
    en_wr = 1'b1; en_wdata = 4'hF; INTD = 1'b0; irq_in = '0;
    tick();
    en_wr = 1'b0;

    // edge and ack on the same source in one cycle
    irq_in = 4'b0001;
    tick(); tick();
    irq_in = '0;
    tick();
    irq_in = 4'b0001; cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    check("t5_set_wins", 32'(pending), 32'h1);
    cpu_eret = 1'b1;
    tick();
    cpu_eret = 1'b0;
    tick();
    check("t5_second", 32'({cpu_irq, vector}), 32'({1'b1, 3'd1}));
    serve();
    irq_in = '0;
    tick();

    // reset in SERVICE discards pending
    irq_in = 4'b0001;
    tick(); tick();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0; irq_in = 4'b1011;
    tick();
    check("t6_pending", 32'(pending), 32'hA);
    rst = 1'b1; irq_in = '0;
    tick();
    check("t6_rst", 32'({cpu_irq, INA, vector, in_service, pending, irq_en}), 32'h000F);
    rst = 1'b0;
    tick();

`ifdef INTC_NMI_PREEMPT_EN
    irq_in = 4'b0100;
    tick(); tick();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0; nmi_in = 1'b1;
    tick(); tick();
    check("t7_nmi_pre", 32'({cpu_irq, INA, vector}), 32'({1'b1, 1'b0, 3'd0}));
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0; cpu_eret = 1'b1;
    tick();
    check("t7_restore", 32'({in_service, INA, vector}), 32'({1'b1, 1'b1, 3'd3}));
    tick();
    cpu_eret = 1'b0; irq_in = '0; nmi_in = 1'b0;
    tick();
`endif

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < NUM_IRQ; b++)
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(0, 15) == 0) nmi_in = ~nmi_in;
      INTD         = ($urandom_range(0, 4) == 0);
      en_wr        = ($urandom_range(0, 19) == 0);
      en_wdata     = 4'($urandom);
      cpu_boundary = $urandom_range(0, 1) == 1;
      cpu_ack      = ($urandom_range(0, 2) == 0);
      cpu_eret     = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
